inst_fetch_queue: RTL and testbench

- Dual-write, dual-read instruction queue between the instruction-cache fetch stage and decode/issue.
- Each cycle it accepts 0-2 fetched instructions with their PCs, the same pair the icache returns as inst_rdata1/inst_rdata2.
- Each cycle it presents the two oldest entries to the dual-issue decoder, which consumes 0-2.
- Decouples fetch stalls from issue stalls and drives the fetch-side stall when space runs short.

---
 rtl/inst_fetch_queue.sv | 112 +++++++++++
 tb/tb_inst_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Dual-write, dual-read instruction queue between icache fetch and decode/issue.
// First-word-fall-through read side; pushes and pops are clipped to the
// free space and occupancy seen at the start of the cycle.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push_en1,
  input  logic                 push_en2,
  input  logic [31:0]          push_inst1,
  input  logic [31:0]          push_inst2,
  input  logic [31:0]          push_pc1,
  input  logic                 pop_en1,
  input  logic                 pop_en2,
  output logic                 out_valid1,
  output logic                 out_valid2,
  output logic [31:0]          out_inst1,
  output logic [31:0]          out_inst2,
  output logic [31:0]          out_pc1,
  output logic [31:0]          out_pc2,
  output logic                 almost_full,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   count
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] TWO_C   = (PTR_WIDTH+1)'(2);

  logic [31:0]          inst_mem [DEPTH];
  logic [31:0]          pc_mem   [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_p1;
  logic [PTR_WIDTH-1:0] rd_ptr_p1;
  logic [PTR_WIDTH:0]   cnt;
  logic [PTR_WIDTH:0]   free_slots;
  logic [PTR_WIDTH:0]   npush;
  logic [PTR_WIDTH:0]   npop;

  // Effective push/pop amounts, clipped against pre-cycle occupancy
  always_comb begin
    free_slots = DEPTH_C - cnt;
    npush      = '0;
    npop       = '0;
    if (push_en1) begin
      npush = push_en2 ? TWO_C : ONE_C;
    end
    if (npush > free_slots) begin
      npush = free_slots;
    end
    if (pop_en1) begin
      npop = pop_en2 ? TWO_C : ONE_C;
    end
    if (npop > cnt) begin
      npop = cnt;
    end
  end

  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign rd_ptr_p1 = rd_ptr + 1'b1;

  // Pointer and occupancy state; flush overrides any push/pop this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + npush[PTR_WIDTH-1:0];
      rd_ptr <= rd_ptr + npop[PTR_WIDTH-1:0];
      cnt    <= cnt + npush - npop;
    end
  end

  // Entry storage writes; second word's PC is derived from the first
  always_ff @(posedge clk) begin
    if (!flush && !rst) begin
      if (npush != '0) begin
        inst_mem[wr_ptr] <= push_inst1;
        pc_mem[wr_ptr]   <= push_pc1;
      end
      if (npush == TWO_C) begin
        inst_mem[wr_ptr_p1] <= push_inst2;
        pc_mem[wr_ptr_p1]   <= push_pc1 + 32'd4;
      end
    end
  end

  // Fall-through read ports, zeroed when the slot is not occupied
  always_comb begin
    out_valid1 = (cnt >= ONE_C);
    out_valid2 = (cnt >= TWO_C);
    out_inst1  = out_valid1 ? inst_mem[rd_ptr]    : '0;
    out_pc1    = out_valid1 ? pc_mem[rd_ptr]      : '0;
    out_inst2  = out_valid2 ? inst_mem[rd_ptr_p1] : '0;
    out_pc2    = out_valid2 ? pc_mem[rd_ptr_p1]   : '0;
  end

  assign almost_full = (cnt >= (DEPTH_C - ONE_C));
  assign empty       = (cnt == '0);
  assign count       = cnt;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based reference model
// checked every cycle, a vector table, and hand-written corner sequences.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_en1, push_en2;
  logic [31:0] push_inst1, push_inst2, push_pc1;
  logic        pop_en1, pop_en2;
  logic        out_valid1, out_valid2;
  logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
  logic        almost_full, empty;
  logic [4:0]  count;

  int n_cmp;
  int n_bad;

  logic [63:0] model_q[$];

  typedef struct {
    logic        pe1;
    logic        pe2;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc;
    logic        po1;
    logic        po2;
    logic        fl;
    int          exp_count;
  } vec_t;

  vec_t vt[$];

  inst_fetch_queue #(.DEPTH(16), .PTR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_en1   (push_en1),
    .push_en2   (push_en2),
    .push_inst1 (push_inst1),
    .push_inst2 (push_inst2),
    .push_pc1   (push_pc1),
    .pop_en1    (pop_en1),
    .pop_en2    (pop_en2),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_inst1  (out_inst1),
    .out_inst2  (out_inst2),
    .out_pc1    (out_pc1),
    .out_pc2    (out_pc2),
    .almost_full(almost_full),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare all outputs against the reference model contents
  task automatic check_all(input string nm);
    int sz;
    logic [63:0] e0, e1;
    sz = model_q.size();
    e0 = (sz >= 1) ? model_q[0] : 64'd0;
    e1 = (sz >= 2) ? model_q[1] : 64'd0;
    cmp({nm, ".count"},  32'(count), 32'(sz));
    cmp({nm, ".empty"},  32'(empty), 32'(sz == 0));
    cmp({nm, ".afull"},  32'(almost_full), 32'(sz >= 15));
    cmp({nm, ".valid1"}, 32'(out_valid1), 32'(sz >= 1));
    cmp({nm, ".valid2"}, 32'(out_valid2), 32'(sz >= 2));
    cmp({nm, ".inst1"},  out_inst1, e0[63:32]);
    cmp({nm, ".pc1"},    out_pc1,   e0[31:0]);
    cmp({nm, ".inst2"},  out_inst2, e1[63:32]);
    cmp({nm, ".pc2"},    out_pc2,   e1[31:0]);
  endtask

  // Drive one cycle of stimulus, advance the model, check after the edge
  task automatic step(input string nm, input logic pe1, input logic pe2,
                      input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc,
                      input logic po1, input logic po2, input logic fl);
    int np, nq, sz;
    push_en1 = pe1; push_en2 = pe2;
    push_inst1 = i1; push_inst2 = i2; push_pc1 = pc;
    pop_en1 = po1; pop_en2 = po2; flush = fl;
    sz = model_q.size();
    np = pe1 ? (pe2 ? 2 : 1) : 0;
    if (np > 16 - sz) np = 16 - sz;
    nq = po1 ? (po2 ? 2 : 1) : 0;
    if (nq > sz) nq = sz;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      for (int k = 0; k < nq; k++) void'(model_q.pop_front());
      if (np >= 1) model_q.push_back({i1, pc});
      if (np == 2) model_q.push_back({i2, pc + 32'd4});
    end
    #1;
    check_all(nm);
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic pe1, input logic pe2, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [31:0] pc, input logic po1,
                              input logic po2, input logic fl, input int ec);
    vec_t v;
    v.pe1 = pe1; v.pe2 = pe2; v.i1 = i1; v.i2 = i2; v.pc = pc;
    v.po1 = po1; v.po2 = po2; v.fl = fl; v.exp_count = ec;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Vector table: fill from empty, clip at full, pop/push interplay at full
    for (int k = 0; k < 8; k++) begin
      vt.push_back(mk(1, 1, 32'hA000_0000 + 32'(2*k), 32'hA000_0001 + 32'(2*k),
                      32'h0000_1000 + 32'(8*k), 0, 0, 0, 2*k + 2));
    end
    vt.push_back(mk(1, 1, 32'hDEAD_0001, 32'hDEAD_0002, 32'h0000_9000, 0, 0, 0, 16));
    vt.push_back(mk(1, 0, 32'hDEAD_0003, 32'h0, 32'h0000_9010, 0, 1, 0, 16));
    vt.push_back(mk(1, 1, 32'hDEAD_0004, 32'hDEAD_0005, 32'h0000_9020, 1, 1, 0, 14));
    vt.push_back(mk(1, 1, 32'hB000_0000, 32'hB000_0001, 32'h0000_5000, 0, 0, 0, 16));
    vt.push_back(mk(1, 1, 32'hDEAD_0006, 32'hDEAD_0007, 32'h0000_9030, 1, 0, 0, 15));
    vt.push_back(mk(1, 1, 32'hC000_0000, 32'hDEAD_0008, 32'h0000_6000, 0, 0, 0, 16));
    vt.push_back(mk(0, 1, 32'hDEAD_0009, 32'hDEAD_000A, 32'h0000_9040, 0, 1, 0, 16));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0, 14));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0));

    rst = 1'b1; flush = 1'b0;
    push_en1 = 1'b0; push_en2 = 1'b0; push_inst1 = '0; push_inst2 = '0; push_pc1 = '0;
    pop_en1 = 1'b0; pop_en2 = 1'b0;
    #12;
    check_all("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset");

    // Dual push then dual pop
    step("dpush", 1, 1, 32'h2402_0001, 32'h2403_0002, 32'hBFC0_0000, 0, 0, 0);
    cmp("dpush.count", 32'(count), 32'd2);
    cmp("dpush.pc2", out_pc2, 32'hBFC0_0004);
    cmp("dpush.inst2", out_inst2, 32'h2403_0002);
    step("dpop", 0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
    cmp("dpop.empty", 32'(empty), 32'd1);

    foreach (vt[i]) begin
      step($sformatf("vec%0d", i), vt[i].pe1, vt[i].pe2, vt[i].i1, vt[i].i2, vt[i].pc,
           vt[i].po1, vt[i].po2, vt[i].fl);
      cmp($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].exp_count));
    end

    // Wrap-around: 15 singles, 15 pops, then a pair straddling slot 15/0
    for (int k = 0; k < 15; k++) begin
      step("wfill", 1, 0, 32'hE000_0000 + 32'(k), 32'h0, 32'h0000_2000 + 32'(4*k), 0, 0, 0);
      if (k == 13) cmp("wfill.afull14", 32'(almost_full), 32'd0);
    end
    cmp("wfill.afull15", 32'(almost_full), 32'd1);
    for (int k = 0; k < 15; k++) begin
      step("wdrain", 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    end
    step("wpair", 1, 1, 32'hF000_0001, 32'hF000_0002, 32'h0000_3000, 0, 0, 0);
    cmp("wrap.pc1", out_pc1, 32'h0000_3000);
    cmp("wrap.pc2", out_pc2, 32'h0000_3004);
    cmp("wrap.inst2", out_inst2, 32'hF000_0002);

    // Partial pop with simultaneous dual push at count 1
    step("to_one", 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    step("simul", 1, 1, 32'h1111_0001, 32'h1111_0002, 32'h0000_4000, 1, 1, 0);
    cmp("simul.count", 32'(count), 32'd2);
    cmp("simul.inst1", out_inst1, 32'h1111_0001);

    // Flush wins over push and pop in the same cycle
    step("f_a", 1, 1, 32'h2222_0001, 32'h2222_0002, 32'h0000_7000, 0, 0, 0);
    step("f_b", 1, 0, 32'h2222_0003, 32'h0, 32'h0000_7008, 0, 0, 0);
    cmp("flush.pre", 32'(count), 32'd5);
    step("flush", 1, 1, 32'h3333_0001, 32'h3333_0002, 32'h0000_8000, 1, 0, 1);
    cmp("flush.count", 32'(count), 32'd0);
    cmp("flush.empty", 32'(empty), 32'd1);
    idle("flush_idle");

    // Asynchronous reset in the middle of a cycle
    step("r_a", 1, 1, 32'h4444_0001, 32'h4444_0002, 32'h0000_A000, 0, 0, 0);
    step("r_b", 1, 1, 32'h4444_0003, 32'h4444_0004, 32'h0000_A008, 0, 0, 0);
    push_en1 = 1'b0; push_en2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    cmp("arst.count", 32'(count), 32'd0);
    cmp("arst.empty", 32'(empty), 32'd1);
    cmp("arst.valid1", 32'(out_valid1), 32'd0);
    cmp("arst.inst1", out_inst1, 32'd0);
    cmp("arst.afull", 32'(almost_full), 32'd0);
    #3 rst = 1'b0;
    idle("arst_idle");
    step("arst_push", 1, 0, 32'h5555_0001, 32'h0, 32'h0000_B000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
